// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: word-addressed array with byte/halfword/word lanes,
// WAIT_STATES wait cycles per OKAY data phase and a two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [1:0]            htrans,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  r_dp_vld;
  logic                  r_write;
  logic [1:0]            r_size;
  logic [1:0]            r_lane;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_accept;
  logic                  w_err;
  logic                  w_commit;
  logic [3:0]            w_be;
  logic [ADDR_WIDTH-3:0] w_idx_full;
  logic                  w_unused;

  assign w_unused   = ^{hburst, htrans[0]};
  assign w_accept   = hsel & hready & htrans[1];
  assign w_idx_full = haddr[ADDR_WIDTH-1:2];

  assign w_err = (w_idx_full >= (ADDR_WIDTH-2)'(MEM_DEPTH))
               | (hsize > 3'd2)
               | ((hsize == 3'd1) & haddr[0])
               | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    hreadyout   = 1'b1;
    hresp       = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_ERR2: begin
        hresp       = (r_state == ST_ERR2);
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = ST_IDLE;
      end
      ST_ERR1: begin
        hreadyout   = 1'b0;
        hresp       = 1'b1;
        w_state_nxt = ST_ERR2;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // r_dp_vld marks a non-errored data phase in flight; it drops once that phase completes.
  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_dp_vld <= 1'b0;
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_lane   <= 2'd0;
      r_idx    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_dp_vld <= ~w_err;
        r_write  <= hwrite;
        r_size   <= hsize[1:0];
        r_lane   <= haddr[1:0];
        r_idx    <= w_idx_full[IDX_W-1:0];
      end else if (hreadyout) begin
        r_dp_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_commit = r_dp_vld & r_write & hreadyout;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  // Writes land on the edge that starts the next data phase, so no forwarding is needed.
  assign hrdata = (r_dp_vld & ~r_write) ? r_mem[r_idx] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: one instance with zero wait states and one with two,
// driven by a pipelined AHB master from a vector table plus reset corner cases.
module tb_ahb_slave_mem;
  localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        use_ws2;
  logic        ro0, resp0, ro2, resp2;
  logic [31:0] rd0, rd2;
  logic        w_hready, w_hresp;
  logic [31:0] w_hrdata;

  vec_t vt[64];
  int   nv = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign w_hready = use_ws2 ? ro2   : ro0;
  assign w_hresp  = use_ws2 ? resp2 : resp0;
  assign w_hrdata = use_ws2 ? rd2   : rd0;

  ahb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .hresetn(hresetn), .hsel(hsel & ~use_ws2), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .htrans(htrans),
    .hwdata(hwdata), .hready(w_hready), .hreadyout(ro0), .hresp(resp0), .hrdata(rd0)
  );

  ahb_slave_mem #(.WAIT_STATES(2)) dut2 (
    .clk(clk), .hresetn(hresetn), .hsel(hsel & use_ws2), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .htrans(htrans),
    .hwdata(hwdata), .hready(w_hready), .hreadyout(ro2), .hresp(resp2), .hrdata(rd2)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] t, input logic w, input logic [2:0] s,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic e);
    vt[nv].trans = t;
    vt[nv].wr    = w;
    vt[nv].sz    = s;
    vt[nv].addr  = a;
    vt[nv].wdata = wd;
    vt[nv].rdata = rd;
    vt[nv].err   = e;
    nv++;
  endtask

  // Expected {wait cycles, hresp while stalled, hresp at completion, hrdata at completion}.
  function automatic logic [37:0] expect_of(input int i, input int ws);
    logic [3:0]  w;
    logic [31:0] rd;
    w  = vt[i].err ? 4'd1 : (vt[i].trans[1] ? 4'(ws) : 4'd0);
    rd = (vt[i].trans[1] && !vt[i].wr && !vt[i].err) ? vt[i].rdata : 32'h0;
    return {w, vt[i].err, vt[i].err, rd};
  endfunction

  task automatic drive_addr(input int i, input int hi);
    if (i <= hi) begin
      hsel   = 1'b1;
      htrans = vt[i].trans;
      hwrite = vt[i].wr;
      hsize  = vt[i].sz;
      haddr  = vt[i].addr;
      hburst = 3'd3;
    end else begin
      hsel   = 1'b0;
      htrans = ID;
      hwrite = 1'b0;
      hsize  = 3'd0;
      haddr  = 32'h0;
      hburst = 3'd0;
    end
  endtask

  task automatic run_seq(input int lo, input int hi, input int ws);
    int          ai, dpi, waits, budget;
    logic        resp_w, rdy;
    logic [37:0] exp_q[$];
    logic [37:0] e, a;
    ai = lo; dpi = -1; waits = 0; resp_w = 1'b0; budget = 0;
    drive_addr(ai, hi);
    while ((ai <= hi || dpi >= 0) && budget < 400) begin
      @(negedge clk);
      budget++;
      rdy = w_hready;
      if (!rdy) begin
        waits++;
        if (w_hresp) resp_w = 1'b1;
      end else begin
        if (dpi >= 0) begin
          e = exp_q.pop_front();
          a = {4'(waits), resp_w, w_hresp, w_hrdata};
          cmp($sformatf("vec%0d", dpi), {26'h0, a}, {26'h0, e});
        end
        if (ai <= hi) begin
          exp_q.push_back(expect_of(ai, ws));
          dpi = ai;
          ai++;
        end else begin
          dpi = -1;
        end
        waits = 0; resp_w = 1'b0;
      end
      @(posedge clk); #1;
      if (rdy) begin
        hwdata = (dpi >= 0) ? vt[dpi].wdata : 32'h0;
        drive_addr(ai, hi);
      end
    end
    if (budget >= 400) begin
      n_vec++; n_bad++;
      $display("FAIL seq_timeout: vectors %0d..%0d did not complete", lo, hi);
    end
  endtask

  // Word access at 0x8 on the two-wait-state slave, reset while it is stalled.
  task automatic rst_mid_wait(input logic wr, input logic [31:0] exp_rd);
    hsel = 1'b1; htrans = NS; hwrite = wr; hsize = 3'd2; haddr = 32'h8; hburst = 3'd0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = ID; hwdata = 32'h12345678;
    @(negedge clk);
    cmp($sformatf("wait_wr%0d", wr), {30'h0, ro2, resp2, rd2}, {30'h0, 1'b0, 1'b0, exp_rd});
    hresetn = 1'b0;
    #1;
    cmp($sformatf("rst_wr%0d", wr), {30'h0, ro2, resp2, rd2}, {30'h0, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    hresetn = 1'b1;
    hwdata  = 32'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    int na, nb;
    hresetn = 1'b0; use_ws2 = 1'b0; hwdata = 32'h0;
    hsel = 1'b0; htrans = ID; hwrite = 1'b0; hsize = 3'd0; haddr = 32'h0; hburst = 3'd0;

    add(NS, 1, 3'd2, 32'h004, 32'hDEADBEEF, 32'h0,        0);
    add(NS, 0, 3'd2, 32'h004, 32'h0,        32'hDEADBEEF, 0);
    add(NS, 1, 3'd2, 32'h004, 32'h11223344, 32'h0,        0);
    add(NS, 1, 3'd0, 32'h005, 32'h0000AA00, 32'h0,        0);
    add(NS, 1, 3'd1, 32'h006, 32'h55660000, 32'h0,        0);
    add(NS, 0, 3'd2, 32'h004, 32'h0,        32'h5566AA44, 0);
    add(NS, 0, 3'd1, 32'h006, 32'h0,        32'h5566AA44, 0);
    add(NS, 0, 3'd2, 32'h400, 32'h0,        32'h0,        1);
    add(NS, 1, 3'd1, 32'h007, 32'hFFFFFFFF, 32'h0,        1);
    add(NS, 0, 3'd2, 32'h004, 32'h0,        32'h5566AA44, 0);
    add(NS, 1, 3'd2, 32'h008, 32'h01020304, 32'h0,        0);
    add(NS, 1, 3'd3, 32'h008, 32'hFFFFFFFF, 32'h0,        1);
    add(NS, 1, 3'd2, 32'h002, 32'hFFFFFFFF, 32'h0,        1);
    add(NS, 0, 3'd2, 32'h008, 32'h0,        32'h01020304, 0);
    add(NS, 1, 3'd2, 32'h024, 32'h00000055, 32'h0,        0);
    add(NS, 1, 3'd2, 32'h010, 32'h1,        32'h0,        0);
    add(SQ, 1, 3'd2, 32'h014, 32'h2,        32'h0,        0);
    // BUSY aimed at a known word so a stray write would show on readback.
    add(BZ, 1, 3'd2, 32'h024, 32'hBAD0BAD0, 32'h0,        0);
    add(SQ, 1, 3'd2, 32'h018, 32'h3,        32'h0,        0);
    add(SQ, 1, 3'd2, 32'h01C, 32'h4,        32'h0,        0);
    add(NS, 0, 3'd2, 32'h010, 32'h0,        32'h1,        0);
    add(SQ, 0, 3'd2, 32'h014, 32'h0,        32'h2,        0);
    add(SQ, 0, 3'd2, 32'h018, 32'h0,        32'h3,        0);
    add(SQ, 0, 3'd2, 32'h01C, 32'h0,        32'h4,        0);
    add(NS, 0, 3'd2, 32'h024, 32'h0,        32'h55,       0);
    add(NS, 1, 3'd0, 32'h013, 32'h7F000000, 32'h0,        0);
    add(NS, 0, 3'd2, 32'h010, 32'h0,        32'h7F000001, 0);
    add(ID, 0, 3'd0, 32'h000, 32'h0,        32'h0,        0);
    add(NS, 1, 3'd2, 32'h3FC, 32'hA5A5A5A5, 32'h0,        0);
    add(NS, 0, 3'd2, 32'h3FC, 32'h0,        32'hA5A5A5A5, 0);
    na = nv;
    add(NS, 1, 3'd2, 32'h008, 32'hCAFEF00D, 32'h0,        0);
    add(NS, 0, 3'd2, 32'h008, 32'h0,        32'hCAFEF00D, 0);
    add(NS, 0, 3'd2, 32'h400, 32'h0,        32'h0,        1);
    add(NS, 0, 3'd2, 32'h008, 32'h0,        32'hCAFEF00D, 0);
    nb = nv;
    add(NS, 0, 3'd2, 32'h008, 32'h0,        32'hCAFEF00D, 0);
    add(NS, 1, 3'd1, 32'h00A, 32'hBEEF0000, 32'h0,        0);
    add(NS, 0, 3'd2, 32'h008, 32'h0,        32'hBEEFF00D, 0);

    #12;
    cmp("reset_ws0", {30'h0, ro0, resp0, rd0}, {30'h0, 1'b1, 1'b0, 32'h0});
    cmp("reset_ws2", {30'h0, ro2, resp2, rd2}, {30'h0, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    hresetn = 1'b1;
    @(posedge clk); #1;

    run_seq(0, na - 1, 0);
    use_ws2 = 1'b1;
    run_seq(na, nb - 1, 2);
    rst_mid_wait(1'b1, 32'h0);
    rst_mid_wait(1'b0, 32'hCAFEF00D);
    run_seq(nb, nv - 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite memory slave: the responder at the far end of the bus driven by `top_ahb`'s master. It accepts NONSEQ/SEQ transfers, performs word/halfword/byte writes and reads on an internal word-addressed array, and inserts a configurable number of wait states. It raises a two-cycle ERROR response for illegal accesses. It sits on an `hsel` output of the decoder; its `hreadyout`, `hresp` and `hrdata` go to the read-data mux.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data bus width (fixed at 32)
- `MEM_DEPTH`, 256, number of 32-bit words
- `WAIT_STATES`, 0, wait cycles inserted per OKAY data phase (0..15)

- `clk`  in  1  bus clock, all logic on rising edge
- `hresetn`  in  1  asynchronous, active-low reset
- `hsel`  in  1  slave select (address phase)
- `haddr`  in  ADDR_WIDTH  byte address
- `hwrite`  in  1  1 = write, 0 = read
- `hsize`  in  3  0 = byte, 1 = halfword, 2 = word
- `hburst`  in  3  burst type; informational only
- `htrans`  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- `hwdata`  in  DATA_WIDTH  write data (data phase)
- `hready`  in  1  bus ready (previous transfer complete)
- `hreadyout`  out  1  this slave's data phase complete
- `hresp`  out  1  0 = OKAY, 1 = ERROR
- `hrdata`  out  DATA_WIDTH  read data

## Operation
- **Accept condition:** `hsel & hready & htrans[1]`. On the accepting edge, register `haddr`, `hwrite`, `hsize`, and the error flag.
- **IDLE/BUSY** with `hsel`, and any cycle without accept, give a zero-wait OKAY data phase.
- **Error flag** is set on any of:
  - word index `haddr[ADDR_WIDTH-1:2]` ≥ MEM_DEPTH
  - `hsize` > 2
  - `hsize`=1 with `haddr[0]`=1
  - `hsize`=2 with `haddr[1:0]`≠0
- **FSM states:** `IDLE`, `WAIT`, `ERR1`, `ERR2`.
  - `IDLE`: `hreadyout`=1, `hresp`=0.
    - Accept without error goes to `WAIT` if WAIT_STATES>0 (counter loaded with WAIT_STATES); otherwise the data phase completes next cycle in `IDLE` (pipelined).
    - Accept with error goes to `ERR1`.
  - `WAIT`: `hreadyout`=0. Counter decrements each cycle. On reaching 1, the next cycle is the completing cycle with `hreadyout`=1.
  - `ERR1`: `hreadyout`=0, `hresp`=1. Always goes to `ERR2`.
  - `ERR2`: `hreadyout`=1, `hresp`=1. Goes to `IDLE`, or straight to the next transfer if one is accepted this cycle (`hready`=1).
- No accept occurs while `hreadyout`=0. `hready` is low because the bus reflects this slave.
- **Write commit:** at the clock edge ending the completing data-phase cycle, lanes selected by `hsize`/`haddr[1:0]` are written from `hwdata`, little-endian (byte n = bits 8n+7:8n). Errored writes never modify memory.
- **Read data:** `hrdata` = `mem[addr_q]` while a non-errored read data phase is active, else 0. Full word is driven regardless of `hsize`.
- **Read-after-write:** a read whose data phase follows a write data phase to the same word returns the new data.
- **Bursts:** `hburst` is ignored. SEQ addresses are used as presented by the master.
- **Reset:** asynchronous reset clears FSM, counter and captured registers; memory contents are not reset. A reset mid-transfer aborts it with no memory write.

## Timing
- **Reset values:** `hreadyout`=1, `hresp`=0, `hrdata`=0.
- **Address-to-data:** one cycle. The data phase lasts 1+WAIT_STATES cycles for OKAY and exactly 2 cycles for ERROR.
- **Back-to-back:** with WAIT_STATES=0, one transfer completes per cycle.
- **Wait states:** with WAIT_STATES=N, `hreadyout` is low for exactly N cycles per transfer.
- **Outputs:** `hreadyout` and `hresp` are registered (from FSM state). `hrdata` is combinational from registered address and memory.

## Test plan
- Reset asserted mid-`WAIT` (WAIT_STATES=2) -> outputs immediately `hreadyout`=1, `hresp`=0, `hrdata`=0; target word unchanged.
- WAIT_STATES=0: NONSEQ word write 0x4 = 0xDEADBEEF, then NONSEQ word read 0x4 on the next cycle -> `hrdata`=0xDEADBEEF, `hresp`=0, no cycle with `hreadyout`=0.
- Word 0x4 = 0x11223344; byte write 0x5 with `hwdata`=0x0000AA00; halfword write 0x6 with `hwdata`=0x55660000 -> read 0x4 returns 0x5566AA44.
- Word read at 0x400 (MEM_DEPTH=256), and halfword write at 0x7 -> each gives (`hreadyout`,`hresp`) = (0,1) then (1,1). `hrdata`=0 and memory unchanged. A NONSEQ accepted during `ERR2` completes OKAY.
- WAIT_STATES=2: write 0x8 = 0xCAFEF00D then read 0x8 -> `hreadyout` low exactly 2 cycles in each data phase; read returns 0xCAFEF00D.
- INCR4 writes 0x10,0x14,0x18,0x1C = 1,2,3,4 with a BUSY cycle after the second -> BUSY cycle zero-wait OKAY with no write; reads return 1,2,3,4.
